// File: rtl/beat_tempo_tracker_if.sv
// Beat tracker port bundle: frame strobe and beat flag in, tempo outputs back.
interface beat_tempo_tracker_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             frame_tick;
    logic             beat_in;
    logic             beat_pulse;
    logic [CNT_W-1:0] interval_frames;
    logic [7:0]       bpm;
    logic             bpm_valid;
    logic             bpm_update;
    logic             locked;

    modport master (
        output frame_tick, beat_in,
        input  beat_pulse, interval_frames, bpm, bpm_valid, bpm_update, locked
    );

    modport slave (
        input  frame_tick, beat_in,
        output beat_pulse, interval_frames, bpm, bpm_valid, bpm_update, locked
    );
endinterface

// File: rtl/beat_tempo_tracker.sv
// Beat tempo tracker: refractory filter, interval history average, restoring divide to BPM.
// Define BPM_OCTAVE_FOLD_EN to fold the result into the 80..159 BPM octave.
module beat_tempo_tracker #(
    parameter int unsigned FRAMES_PER_MIN = 5625,
    parameter int unsigned MIN_INTERVAL   = 23,
    parameter int unsigned MAX_INTERVAL   = 140,
    parameter int unsigned HIST_DEPTH     = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DIV_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    beat_tempo_tracker_if.slave  bus
);
    localparam int unsigned HW = $clog2(HIST_DEPTH);
    localparam int unsigned FW = $clog2(HIST_DEPTH + 1);
    localparam int unsigned BW = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(FRAMES_PER_MIN * HIST_DEPTH);
    localparam logic [CNT_W-1:0] D_SAT    = CNT_W'(MAX_INTERVAL + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(HIST_DEPTH);

    typedef enum logic {StSearch, StTrack} trk_state_e;
`ifdef BPM_OCTAVE_FOLD_EN
    typedef enum logic [1:0] {StIdle, StDivide, StFold} div_state_e;
`else
    typedef enum logic [1:0] {StIdle, StDivide} div_state_e;
`endif

    trk_state_e       r_trk_state, w_trk_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_d;
    logic [CNT_W-1:0] r_hist [HIST_DEPTH];
    logic [HW-1:0]    r_wr_ptr;
    logic [FW-1:0]    r_fill, w_fill_inc;
    logic [DIV_W-1:0] r_sum, w_sum_new;
    logic             r_beat_pulse, r_locked, r_bpm_valid, r_bpm_update, r_div_req;
    logic [CNT_W-1:0] r_interval;
    logic [7:0]       r_bpm;
    logic             w_accept, w_timeout, w_lock, w_req_new;

    div_state_e       r_div_state, w_div_next;
    logic [DIV_W-1:0] r_rem, r_quo, r_dvsr;
    logic [BW-1:0]    r_bit_cnt;
    logic [DIV_W:0]   w_rem_sh;
    logic [DIV_W-1:0] w_rem_diff, w_rem_step, w_quo_step;
    logic             w_ge, w_last, w_start, w_done;
    logic [7:0]       w_raw_bpm, w_result;
`ifdef BPM_OCTAVE_FOLD_EN
    logic [7:0]       r_fold, w_fold_step;
    logic             w_fold_load;

    function automatic logic in_band(input logic [7:0] v);
        return (v == 8'd0) || ((v >= 8'd80) && (v < 8'd160));
    endfunction

    function automatic logic [7:0] fold_once(input logic [7:0] v);
        return (v < 8'd80) ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
    endfunction
`endif

    // ---------------- beat tracking ----------------
    assign w_d        = (r_cnt >= D_SAT) ? D_SAT : r_cnt + 1'b1;
    assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign w_sum_new  = r_sum - DIV_W'(r_hist[r_wr_ptr]) + DIV_W'(w_d);
    assign w_req_new  = w_accept && (w_fill_inc == FILL_MAX);

    always_comb begin
        w_trk_next = r_trk_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_timeout  = 1'b0;
        w_lock     = 1'b0;
        if (bus.frame_tick) begin
            case (r_trk_state)
                StSearch: begin
                    if (bus.beat_in) begin
                        w_lock     = 1'b1;
                        w_trk_next = StTrack;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = w_d;
                    end
                end
                StTrack: begin
                    // Counter never exceeds MAX_INTERVAL in TRACK, so d>MAX only on the
                    // first frame past the window; a beat there is too late to count.
                    if (w_d > CNT_W'(MAX_INTERVAL)) begin
                        w_timeout  = 1'b1;
                        w_trk_next = StSearch;
                        w_cnt_next = w_d;
                    end else if (bus.beat_in && (w_d >= CNT_W'(MIN_INTERVAL))) begin
                        w_accept   = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = w_d;
                    end
                end
                default: w_trk_next = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trk_state  <= StSearch;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_sum        <= '0;
            r_beat_pulse <= 1'b0;
            r_locked     <= 1'b0;
            r_interval   <= '0;
            r_div_req    <= 1'b0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
        end else begin
            r_trk_state  <= w_trk_next;
            r_cnt        <= w_cnt_next;
            r_beat_pulse <= w_lock | w_accept;
            if (w_lock) r_locked <= 1'b1;
            if (w_accept) begin
                r_interval       <= w_d;
                r_hist[r_wr_ptr] <= w_d;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                r_fill           <= w_fill_inc;
                r_sum            <= w_sum_new;
            end
            if (w_timeout) begin
                r_locked <= 1'b0;
                r_wr_ptr <= '0;
                r_fill   <= '0;
                r_sum    <= '0;
                for (int unsigned i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
            end
            // One flag covers both a fresh request and the single pending slot.
            if (w_req_new) r_div_req <= 1'b1;
            else if (w_start || w_timeout) r_div_req <= 1'b0;
        end
    end

    // ---------------- restoring divider ----------------
    assign w_rem_sh   = {r_rem, r_quo[DIV_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_diff = w_rem_sh[DIV_W-1:0] - r_dvsr;
    assign w_rem_step = w_ge ? w_rem_diff : w_rem_sh[DIV_W-1:0];
    assign w_quo_step = {r_quo[DIV_W-2:0], w_ge};
    assign w_last     = (r_bit_cnt == BW'(DIV_W - 1));
    assign w_raw_bpm  = (|w_quo_step[DIV_W-1:8]) ? 8'hFF : w_quo_step[7:0];
`ifdef BPM_OCTAVE_FOLD_EN
    assign w_fold_step = fold_once(r_fold);
`endif

    always_comb begin
        w_div_next = r_div_state;
        w_start    = 1'b0;
        w_done     = 1'b0;
        w_result   = r_bpm;
`ifdef BPM_OCTAVE_FOLD_EN
        w_fold_load = 1'b0;
`endif
        case (r_div_state)
            StIdle: begin
                if (r_div_req) begin
                    w_start    = 1'b1;
                    w_div_next = StDivide;
                end
            end
            StDivide: begin
                if (w_last) begin
`ifdef BPM_OCTAVE_FOLD_EN
                    if (in_band(w_raw_bpm)) begin
                        w_done     = 1'b1;
                        w_result   = w_raw_bpm;
                        w_div_next = StIdle;
                    end else begin
                        w_fold_load = 1'b1;
                        w_div_next  = StFold;
                    end
`else
                    w_done     = 1'b1;
                    w_result   = w_raw_bpm;
                    w_div_next = StIdle;
`endif
                end
            end
`ifdef BPM_OCTAVE_FOLD_EN
            StFold: begin
                if (in_band(w_fold_step)) begin
                    w_done     = 1'b1;
                    w_result   = w_fold_step;
                    w_div_next = StIdle;
                end
            end
`endif
            default: w_div_next = StIdle;
        endcase
        if (w_timeout) begin
            w_div_next = StIdle;
            w_start    = 1'b0;
            w_done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_state  <= StIdle;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvsr       <= '0;
            r_bit_cnt    <= '0;
            r_bpm        <= '0;
            r_bpm_valid  <= 1'b0;
            r_bpm_update <= 1'b0;
`ifdef BPM_OCTAVE_FOLD_EN
            r_fold       <= '0;
`endif
        end else begin
            r_div_state  <= w_div_next;
            r_bpm_update <= w_done;
            if (w_start) begin
                r_rem     <= '0;
                r_quo     <= DIVIDEND;
                r_dvsr    <= r_sum;
                r_bit_cnt <= '0;
            end else if (r_div_state == StDivide) begin
                r_rem     <= w_rem_step;
                r_quo     <= w_quo_step;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
`ifdef BPM_OCTAVE_FOLD_EN
            if (w_fold_load) r_fold <= w_raw_bpm;
            else if (r_div_state == StFold) r_fold <= w_fold_step;
`endif
            if (w_done) begin
                r_bpm       <= w_result;
                r_bpm_valid <= 1'b1;
            end
            if (w_timeout) r_bpm_valid <= 1'b0;
        end
    end

    assign bus.beat_pulse      = r_beat_pulse;
    assign bus.interval_frames = r_interval;
    assign bus.bpm             = r_bpm;
    assign bus.bpm_valid       = r_bpm_valid;
    assign bus.bpm_update      = r_bpm_update;
    assign bus.locked          = r_locked;
endmodule
